// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame/synchronizer sizes.
// Used by both spi_slave and spi_master.
package spi_pkg;

    typedef logic [0:0] spi_state_t;

    localparam spi_state_t IDLE  = 1'b0;
    localparam spi_state_t SHIFT = 1'b1;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset value.
// STAGES must be at least 2.
module spi_sync
    import spi_pkg::*;
#(
    parameter int   STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with oversampled SCLK/MOSI/CS, a one-word transmit holding
// register and back-to-back word support within a single chip-select frame.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  CS,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Reset asserts asynchronously but releases on a clk edge.
    logic rst_meta_q;
    logic rst_n_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    logic sclk_s;
    logic mosi_s;
    logic cs_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n_q), .d(SCLK), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n_q), .d(MOSI), .q(mosi_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n_q), .d(CS), .q(cs_s)
    );

    spi_state_t            state_q,         state_d;
    logic                  sclk_prev_q,     sclk_prev_d;
    logic                  cs_prev_q,       cs_prev_d;
    logic [CNT_W-1:0]      bit_cnt_q,       bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,      rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,      tx_shift_d;
    logic [DATA_WIDTH-1:0] hold_q,          hold_d;
    logic                  hold_full_q,     hold_full_d;
    logic                  reload_pend_q,   reload_pend_d;
    logic                  underrun_pend_q, underrun_pend_d;
    logic [DATA_WIDTH-1:0] rx_data_q,       rx_data_d;
    logic                  rx_valid_q,      rx_valid_d;
    logic                  tx_underrun_q,   tx_underrun_d;
    logic                  frame_err_q,     frame_err_d;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic load;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // A mid-frame reload only flags underrun once the next word actually starts,
    // so the final reload before CS rises does not report a spurious underrun.
    always_comb begin
        state_d         = state_q;
        sclk_prev_d     = sclk_s;
        cs_prev_d       = cs_s;
        bit_cnt_d       = bit_cnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        hold_d          = hold_q;
        hold_full_d     = hold_full_q;
        reload_pend_d   = reload_pend_q;
        underrun_pend_d = underrun_pend_q;
        rx_data_d       = rx_data_q;
        rx_valid_d      = 1'b0;
        tx_underrun_d   = 1'b0;
        frame_err_d     = 1'b0;
        load            = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d         = SHIFT;
                    bit_cnt_d       = '0;
                    rx_shift_d      = '0;
                    reload_pend_d   = 1'b0;
                    underrun_pend_d = 1'b0;
                    load            = 1'b1;
                    tx_underrun_d   = ~hold_full_q;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d         = IDLE;
                    frame_err_d     = (bit_cnt_q != '0);
                    bit_cnt_d       = '0;
                    rx_shift_d      = '0;
                    reload_pend_d   = 1'b0;
                    underrun_pend_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (underrun_pend_q) begin
                        tx_underrun_d   = 1'b1;
                        underrun_pend_d = 1'b0;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d     = rx_shift_d;
                        rx_valid_d    = 1'b1;
                        bit_cnt_d     = '0;
                        reload_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_pend_q) begin
                        load            = 1'b1;
                        reload_pend_d   = 1'b0;
                        underrun_pend_d = ~hold_full_q;
                    end else begin
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A load takes the old holding contents; a same-cycle write then refills it.
        if (load) begin
            tx_shift_d  = hold_full_q ? hold_q : '0;
            hold_full_d = 1'b0;
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q         <= IDLE;
            sclk_prev_q     <= 1'b0;
            cs_prev_q       <= 1'b1;
            bit_cnt_q       <= '0;
            rx_shift_q      <= '0;
            tx_shift_q      <= '0;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            reload_pend_q   <= 1'b0;
            underrun_pend_q <= 1'b0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            tx_underrun_q   <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sclk_prev_q     <= sclk_prev_d;
            cs_prev_q       <= cs_prev_d;
            bit_cnt_q       <= bit_cnt_d;
            rx_shift_q      <= rx_shift_d;
            tx_shift_q      <= tx_shift_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            reload_pend_q   <= reload_pend_d;
            underrun_pend_q <= underrun_pend_d;
            rx_data_q       <= rx_data_d;
            rx_valid_q      <= rx_valid_d;
            tx_underrun_q   <= tx_underrun_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign MISO        = (state_q == SHIFT) & tx_shift_q[DATA_WIDTH-1];
    assign busy        = (state_q == SHIFT);
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;

endmodule
